// File: rtl/hp_fifo.sv
// Purpose     : host-to-parasite byte FIFO (first-word-fall-through) behind the Tube data register.
// Latency     : a byte written at edge N is on p_data right after edge N; a read shows the next entry right after that edge.
// Backpressure: a write to a full FIFO is dropped and sets h_overflow, unless a read is accepted in the same cycle.
//               A read from an empty FIFO sets p_underflow.
//
// Ports
//   p_clk, rst                           single clock; synchronous active-high reset
//   h_data, h_selectData, h_wr, h_phi2_en host write side (write request = AND of the three strobes)
//   h_flush                              one-cycle synchronous flush (same effect as reset)
//   p_selectData, p_rd, p_phi2_en        parasite read side (read request = AND of the three strobes)
//   p_data                               head byte, 8'hAA when empty
//   p_data_available, h_full, level      occupancy flags and count (0..DEPTH)
//   h_overflow, p_underflow              sticky error bits, cleared by reset or flush only
module hp_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          p_clk,
    input  logic          rst,
    input  logic [7:0]    h_data,
    input  logic          h_selectData,
    input  logic          h_wr,
    input  logic          h_phi2_en,
    input  logic          h_flush,
    input  logic          p_selectData,
    input  logic          p_rd,
    input  logic          p_phi2_en,
    output logic [7:0]    p_data,
    output logic          p_data_available,
    output logic          h_full,
    output logic [AW:0]   level,
    output logic          h_overflow,
    output logic          p_underflow
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic          r_underflow;

    logic w_wr_req;
    logic w_rd_req;
    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_clear;

    assign w_wr_req = h_selectData & h_wr & h_phi2_en;
    assign w_rd_req = p_selectData & p_rd & p_phi2_en;
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == L_DEPTH);
    assign w_clear  = rst | h_flush;

    // No bypass: a read against an empty FIFO is never accepted, even if a
    // write lands in the same cycle. A read freeing a slot lets a write into a full FIFO.
    assign w_rd_ok = w_rd_req & ~w_empty;
    assign w_wr_ok = w_wr_req & (~w_full | w_rd_ok);

    // Storage has no reset; gating on w_clear keeps flushed writes out of the array.
    always_ff @(posedge p_clk) begin
        if (w_wr_ok && !w_clear) begin
            r_mem[r_wr_ptr] <= h_data;
        end
    end

    always_ff @(posedge p_clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Pointers are AW bits wide with DEPTH a power of two, so +1 wraps naturally.
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_wr_req && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign p_data           = w_empty ? 8'hAA : r_mem[r_rd_ptr];
    assign p_data_available = ~w_empty;
    assign h_full           = w_full;
    assign level            = r_level;
    assign h_overflow       = r_overflow;
    assign p_underflow      = r_underflow;

endmodule
